bram_arbiter: RTL

Two-requester arbiter in front of one `block_ram_dpi` instance (64-bit data, 32-bit address, 8-bit byte mask, 1-cycle registered read). Requester A (operand fetch) and requester B (result writeback) share the single BRAM port. The block grants at most one access per cycle under round-robin with optional bounded lock. It routes each read's data back to its originator with a per-requester response strobe.

---
 rtl/bram_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbiter with bounded lock, sharing one registered-read
// block RAM port between requester A (operand fetch) and requester B (writeback).
// Read data is steered back to the requester that issued the read.
// Build option: define BRAM_ARB_RSP_REG_EN to register rsp_valid/rsp_rdata
// (read latency 2 instead of 1, throughput unchanged).
module bram_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_we,
    input  logic        a_req_lock,
    input  logic [31:0] a_req_addr,
    input  logic [63:0] a_req_wdata,
    input  logic [7:0]  a_req_wmask,
    output logic        a_rsp_valid,
    output logic [63:0] a_rsp_rdata,

    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_we,
    input  logic        b_req_lock,
    input  logic [31:0] b_req_addr,
    input  logic [63:0] b_req_wdata,
    input  logic [7:0]  b_req_wmask,
    output logic        b_rsp_valid,
    output logic [63:0] b_rsp_rdata,

    output logic [31:0] bram_raddr,
    output logic [31:0] bram_waddr,
    output logic [63:0] bram_wdata,
    output logic [7:0]  bram_wmask,
    output logic        bram_wen,
    input  logic [63:0] bram_rdata
);

    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

    localparam logic [7:0] LOCK_CNT_MAX = 8'(LOCK_MAX);

    req_id_t     last_grant_reg;
    logic        lock_valid_reg, lock_valid_next;
    req_id_t     lock_id_reg, lock_id_next;
    logic [7:0]  lock_cnt_reg, lock_cnt_next;
    logic [7:0]  lock_cnt_inc;
    logic [31:0] raddr_hold_reg;
    logic        pend_valid_reg;
    logic        pend_b_reg;

    logic        owner_req_valid;
    logic        grant_any;
    req_id_t     win_id;
    logic        win_we;
    logic        win_lock;
    logic [31:0] win_addr;
    logic [63:0] win_wdata;
    logic [7:0]  win_wmask;

    logic [1:0]        rsp_hit;
    logic [1:0]        rsp_valid_vec;
    logic [1:0][63:0]  rsp_rdata_vec;

    assign owner_req_valid = (lock_id_reg == REQ_B) ? b_req_valid : a_req_valid;

    // Pick this cycle's winner: unexpired lock owner, else alternate on a tie, else the lone requester.
    always_comb begin
        grant_any = 1'b0;
        win_id    = REQ_A;
        if (rst_n) begin
            if (lock_valid_reg && owner_req_valid && (lock_cnt_reg < LOCK_CNT_MAX)) begin
                grant_any = 1'b1;
                win_id    = lock_id_reg;
            end else if (a_req_valid && b_req_valid) begin
                grant_any = 1'b1;
                win_id    = (last_grant_reg == REQ_A) ? REQ_B : REQ_A;
            end else if (a_req_valid) begin
                grant_any = 1'b1;
                win_id    = REQ_A;
            end else if (b_req_valid) begin
                grant_any = 1'b1;
                win_id    = REQ_B;
            end
        end
    end

    assign win_we    = (win_id == REQ_B) ? b_req_we    : a_req_we;
    assign win_lock  = (win_id == REQ_B) ? b_req_lock  : a_req_lock;
    assign win_addr  = (win_id == REQ_B) ? b_req_addr  : a_req_addr;
    assign win_wdata = (win_id == REQ_B) ? b_req_wdata : a_req_wdata;
    assign win_wmask = (win_id == REQ_B) ? b_req_wmask : a_req_wmask;

    assign a_req_ready = grant_any && (win_id == REQ_A);
    assign b_req_ready = grant_any && (win_id == REQ_B);

    // grant_any is already low during reset, so the write enable is too.
    assign bram_wen   = grant_any && win_we;
    assign bram_waddr = win_addr;
    assign bram_wdata = win_wdata;
    assign bram_wmask = win_wmask;
    assign bram_raddr = grant_any ? win_addr : raddr_hold_reg;

    // Lock bookkeeping: a locked beat extends (or starts) ownership; anything else, or hitting the cap, releases it.
    always_comb begin
        lock_valid_next = lock_valid_reg;
        lock_id_next    = lock_id_reg;
        lock_cnt_next   = lock_cnt_reg;
        lock_cnt_inc    = 8'd1;
        if (lock_valid_reg && !owner_req_valid) begin
            lock_valid_next = 1'b0;
            lock_cnt_next   = 8'd0;
        end
        if (grant_any) begin
            if (win_lock) begin
                if (lock_valid_reg && (lock_id_reg == win_id)) begin
                    lock_cnt_inc = (lock_cnt_reg == 8'hFF) ? 8'hFF : lock_cnt_reg + 8'd1;
                end
                if (lock_cnt_inc >= LOCK_CNT_MAX) begin
                    lock_valid_next = 1'b0;
                    lock_cnt_next   = 8'd0;
                end else begin
                    lock_valid_next = 1'b1;
                    lock_id_next    = win_id;
                    lock_cnt_next   = lock_cnt_inc;
                end
            end else begin
                lock_valid_next = 1'b0;
                lock_cnt_next   = 8'd0;
            end
        end
    end

    // Arbitration state, held read address and the first stage of the read pending pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= REQ_B;
            lock_valid_reg <= 1'b0;
            lock_id_reg    <= REQ_A;
            lock_cnt_reg   <= 8'd0;
            raddr_hold_reg <= 32'd0;
            pend_valid_reg <= 1'b0;
            pend_b_reg     <= 1'b0;
        end else begin
            if (grant_any) begin
                last_grant_reg <= win_id;
                raddr_hold_reg <= win_addr;
            end
            lock_valid_reg <= lock_valid_next;
            lock_id_reg    <= lock_id_next;
            lock_cnt_reg   <= lock_cnt_next;
            pend_valid_reg <= grant_any && !win_we;
            pend_b_reg     <= (win_id == REQ_B);
        end
    end

    // Index 0 is requester A, index 1 is requester B.
    assign rsp_hit = {pend_valid_reg & pend_b_reg, pend_valid_reg & ~pend_b_reg};

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
`ifdef BRAM_ARB_RSP_REG_EN
        logic        valid_reg;
        logic [63:0] rdata_reg;

        // Second pending stage: register the strobe and capture the data that belongs to this requester.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                rdata_reg <= 64'd0;
            end else begin
                valid_reg <= rsp_hit[gi];
                if (rsp_hit[gi]) begin
                    rdata_reg <= bram_rdata;
                end
            end
        end

        assign rsp_valid_vec[gi] = valid_reg;
        assign rsp_rdata_vec[gi] = rdata_reg;
`else
        logic [63:0] rdata_hold_reg;

        // Remember the last delivered word so rdata stays put between strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_hold_reg <= 64'd0;
            end else if (rsp_hit[gi]) begin
                rdata_hold_reg <= bram_rdata;
            end
        end

        assign rsp_valid_vec[gi] = rsp_hit[gi];
        assign rsp_rdata_vec[gi] = rsp_hit[gi] ? bram_rdata : rdata_hold_reg;
`endif
    end

    assign a_rsp_valid = rsp_valid_vec[0];
    assign b_rsp_valid = rsp_valid_vec[1];
    assign a_rsp_rdata = rsp_rdata_vec[0];
    assign b_rsp_rdata = rsp_rdata_vec[1];

endmodule
